// File: rtl/fd_pipe_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fd_pipe_reg_pkg : ExcCodes, vectors and slot type shared by stages |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package fd_pipe_reg_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
    logic        valid;
  } fd_slot_t;

  // A bubble keeps a PC so CP0 always has something sane to report.
  function automatic fd_slot_t bubble_at(input logic [31:0] pc);
    fd_slot_t s;
    s.pc       = pc;
    s.instr    = 32'h0;
    s.exc_code = EXC_NONE;
    s.bd       = 1'b0;
    s.valid    = 1'b0;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fd_pipe_reg_perf_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fd_pipe_reg_perf_counter : wrapping event counter, sync reset      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fd_pipe_reg_perf_counter
  import fd_pipe_reg_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fd_pipe_reg : F->D pipeline register with stall/flush/redirect     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fd_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req,
  input  logic             flush,
  input  logic [31:0]      F_pc,
  input  logic [31:0]      F_instr,
  input  logic             F_excAdEL,
  input  logic             F_bd,
  output logic [31:0]      D_pc,
  output logic [31:0]      D_instr,
  output logic [4:0]       D_excCode,
  output logic             D_bd,
  output logic             D_valid,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  import fd_pipe_reg_pkg::*;

  fd_slot_t r_slot;
  fd_slot_t w_capture;
  logic     w_issue;
  logic     w_stall;

  always_comb begin
    w_capture.pc       = F_pc;
    w_capture.bd       = F_bd;
    w_capture.valid    = 1'b1;
    w_capture.exc_code = F_excAdEL ? EXC_ADEL : EXC_NONE;
    w_capture.instr    = F_excAdEL ? 32'h0 : F_instr;
  end

  // Priority: reset > req > stall hold > flush > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= bubble_at(RESET_PC);
    end else if (req) begin
      r_slot <= bubble_at(HANDLER_PC);
    end else if (en) begin
      if (flush) begin
        r_slot <= bubble_at(F_pc);
      end else begin
        r_slot <= w_capture;
      end
    end
  end

  assign w_issue = !req && en && !flush;
  assign w_stall = !req && !en;

  fd_pipe_reg_perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_issue),
    .count (instr_cnt)
  );

  fd_pipe_reg_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  assign D_pc      = r_slot.pc;
  assign D_instr   = r_slot.instr;
  assign D_excCode = r_slot.exc_code;
  assign D_bd      = r_slot.bd;
  assign D_valid   = r_slot.valid;

endmodule
`default_nettype wire

// File: tb/tb_fd_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fd_pipe_reg : directed + random stimulus against a slot model   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, en, req, flush, F_excAdEL, F_bd;
  logic [31:0] F_pc, F_instr;
  logic [31:0] D_pc, D_instr;
  logic [4:0]  D_excCode;
  logic        D_bd, D_valid;
  logic [31:0] instr_cnt, stall_cnt;

  logic [31:0] s_pc, s_instr;
  logic [4:0]  s_exc;
  logic        s_bd, s_valid;
  logic [3:0]  s_icnt, s_scnt;

  always #5 clk = ~clk;

  fd_pipe_reg dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .flush(flush),
    .F_pc(F_pc), .F_instr(F_instr), .F_excAdEL(F_excAdEL), .F_bd(F_bd),
    .D_pc(D_pc), .D_instr(D_instr), .D_excCode(D_excCode), .D_bd(D_bd),
    .D_valid(D_valid), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy so that modulo wrap is reached within a short run.
  fd_pipe_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .en(en), .req(req), .flush(flush),
    .F_pc(F_pc), .F_instr(F_instr), .F_excAdEL(F_excAdEL), .F_bd(F_bd),
    .D_pc(s_pc), .D_instr(s_instr), .D_excCode(s_exc), .D_bd(s_bd),
    .D_valid(s_valid), .instr_cnt(s_icnt), .stall_cnt(s_scnt)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]     m_pc, m_instr;
  logic [4:0]      m_exc;
  logic            m_bd, m_valid;
  longint unsigned m_icnt, m_scnt;

  always @(posedge clk) begin
    if (!reset && !req && !en && flush) begin
      errors++;
      $error("FAIL flush_in_stall observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("D_pc", D_pc, m_pc);
    chk("D_instr", D_instr, m_instr);
    chk("D_excCode", {27'd0, D_excCode}, {27'd0, m_exc});
    chk("D_bd", {31'd0, D_bd}, {31'd0, m_bd});
    chk("D_valid", {31'd0, D_valid}, {31'd0, m_valid});
    chk("instr_cnt", instr_cnt, 32'(m_icnt % 64'h1_0000_0000));
    chk("stall_cnt", stall_cnt, 32'(m_scnt % 64'h1_0000_0000));
    chk("instr_cnt_w4", {28'd0, s_icnt}, 32'(m_icnt % 16));
    chk("stall_cnt_w4", {28'd0, s_scnt}, 32'(m_scnt % 16));
  endtask

  task automatic step(input logic r, input logic q, input logic e, input logic f,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic adel, input logic bd);
    reset = r; req = q; en = e; flush = f;
    F_pc = pc; F_instr = ins; F_excAdEL = adel; F_bd = bd;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_icnt = 0; m_scnt = 0;
    end else if (q) begin
      m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
    end else if (!e) begin
      m_scnt++;
    end else if (f) begin
      m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
    end else begin
      m_pc = pc; m_bd = bd; m_valid = 1;
      m_exc = adel ? 5'd4 : 5'd0;
      m_instr = adel ? 32'h0 : ins;
      m_icnt++;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic r, q, e, f;
    reset = 1; req = 0; en = 1; flush = 0;
    F_pc = 32'h3000; F_instr = 32'h3c01_0001; F_excAdEL = 0; F_bd = 0;

    step(1, 0, 1, 0, 32'h3000, 32'h3c01_0001, 0, 0);
    step(1, 0, 1, 0, 32'h3000, 32'h3c01_0001, 0, 0);
    chk("reset_pc_const", D_pc, 32'h0);
    step(0, 0, 1, 0, 32'h3000, 32'h3c01_0001, 0, 0);
    chk("first_capture_cnt", instr_cnt, 32'd1);

    step(0, 0, 0, 0, 32'h3004, 32'h1111_1111, 0, 0);
    step(0, 0, 0, 0, 32'h3008, 32'h2222_2222, 0, 1);
    step(0, 0, 0, 0, 32'h300c, 32'h3333_3333, 1, 0);
    chk("stall_pc_hold", D_pc, 32'h3000);
    chk("stall_cnt3", stall_cnt, 32'd3);

    step(0, 0, 1, 0, 32'h3002, 32'hffff_ffff, 1, 0);
    chk("adel_code", {27'd0, D_excCode}, 32'd4);

    step(0, 1, 0, 1, 32'h3008, 32'h1234_5678, 1, 1);
    chk("handler_pc", D_pc, 32'h4180);
    chk("req_no_stall", stall_cnt, 32'd3);

    step(0, 0, 1, 1, 32'h3010, 32'hdead_beef, 0, 1);
    chk("flush_cnt", instr_cnt, 32'd2);

    for (int i = 0; i < 20; i++)
      step(0, 0, 1, 0, 32'h4000 + 32'(i * 4), $urandom, 0, 1'($urandom));

    step(1, 1, 1, 0, 32'h5000, 32'h0bad_f00d, 1, 1);
    chk("reset_beats_req", D_pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      q = ($urandom_range(0, 99) < 6);
      e = ($urandom_range(0, 99) < 75);
      f = e && ($urandom_range(0, 99) < 20);
      step(r, q, e, f, $urandom, $urandom,
           ($urandom_range(0, 99) < 15), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
- F→D pipeline register of the 5-stage MIPS core with precise exceptions; sits directly downstream of the fetch unit and feeds the D-stage decoder and CP0 path.
- Captures the fetched PC and instruction. Attaches the fetch exception code (AdEL) and the branch-delay-slot flag.
- Implements stall hold, bubble insertion (flush), and the interrupt/exception redirect bubble whose PC is the handler entry.
- Keeps two free-running performance counters: issued instructions and stall cycles.

Parameters:
- RESET_PC, 32'h0000_0000, D_pc value after reset.
- HANDLER_PC, 32'h0000_4180, D_pc value loaded on req.
- EXC_ADEL, 5'd4, ExcCode for an instruction-fetch address error.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = advance; 0 = stall (hold all pipeline outputs).
- req  in  1  exception/interrupt taken this cycle (from CP0).
- flush  in  1  replace the incoming slot with a bubble (branch-likely nullify).
- F_pc  in  32  PC presented by fetch this cycle.
- F_instr  in  32  instruction from fetch (already 0 when fetch flags AdEL).
- F_excAdEL  in  1  fetch address-error flag.
- F_bd  in  1  incoming instruction is in a branch delay slot (from D-stage branch decode).
- D_pc  out  32  registered PC.
- D_instr  out  32  registered instruction.
- D_excCode  out  5  registered ExcCode; 0 = none.
- D_bd  out  1  registered delay-slot flag.
- D_valid  out  1  1 = real instruction; 0 = bubble.
- instr_cnt  out  CNT_W  count of instructions issued into D.
- stall_cnt  out  CNT_W  count of stall cycles.

Behaviour:
- Update priority, evaluated each rising edge: reset > req > (en=0 hold) > flush > capture.
- reset=1:
  - D_pc=RESET_PC; D_instr=0; D_excCode=0; D_bd=0; D_valid=0.
  - instr_cnt=0; stall_cnt=0.
- req=1 (overrides en and flush):
  - D_pc=HANDLER_PC; D_instr=0; D_excCode=0; D_bd=0; D_valid=0.
  - Counters unchanged.
- en=0, req=0:
  - All D_* outputs hold.
  - stall_cnt increments by 1. flush is ignored; the hazard unit never asserts it during a stall, and the bench flags it as an assertion.
- en=1, flush=1:
  - D_pc=F_pc, so CP0 still sees a sane PC.
  - D_instr=0; D_excCode=0; D_bd=0; D_valid=0.
- en=1, flush=0 (capture):
  - D_pc=F_pc; D_bd=F_bd; D_valid=1.
  - If F_excAdEL=1: D_excCode=EXC_ADEL and D_instr=0, forced regardless of F_instr.
  - Otherwise: D_excCode=0 and D_instr=F_instr.
  - instr_cnt increments by 1.
- Latency: exactly one cycle from F_* to D_*. No combinational path from any input to any D_* output.
- Counters:
  - Both wrap modulo 2^CNT_W; no saturation.
  - Both are cleared only by reset; req does not clear them.
- eret needs no handling here: fetch already substitutes EPC and suppresses AdEL. The instruction captured after eret is treated as a normal capture.
- reset asserted mid-stall or together with req: reset values win in that same cycle.

Decomposition:
- Shared package/const header:
  - ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12).
  - HANDLER_PC.
  - Reset PC constant.
- Other pipeline registers (D/E, E/M, M/W) reuse these constants.
- One natural sub-module: perf_counter. It is a CNT_W-bit counter with sync reset and increment enable, instantiated twice.

Test Plan:
- Reset held 2 cycles, then released with en=1, F_pc=0x3000, F_instr=0x3c010001 → before release all outputs 0; next edge D_pc=0x3000, D_instr=0x3c010001, D_valid=1, instr_cnt=1.
- en=0 for 3 cycles while F_pc changes 0x3004→0x300c → D_pc stays 0x3000 and D_instr holds; stall_cnt=3, instr_cnt unchanged.
- en=1, F_pc=0x3002, F_excAdEL=1, F_instr=0xffffffff → D_pc=0x3002, D_instr=0, D_excCode=4, D_valid=1.
- req=1 together with en=0 and flush=1 → D_pc=0x4180, D_instr=0, D_excCode=0, D_bd=0, D_valid=0; stall_cnt not incremented.
- en=1, flush=1, F_pc=0x3010, F_bd=1 → D_pc=0x3010, D_instr=0, D_bd=0, D_valid=0; instr_cnt unchanged.
- Force instr_cnt to 0xffffffff, then capture once → instr_cnt=0 (wrap). Then assert reset together with req → all outputs equal the reset values, not HANDLER_PC.
